// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory write port bundle for imem_loader
interface imem_loader_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a big-endian word image into instruction memory
// Optional trailer checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t      state, nxt;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [15:0] hdr_count;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        take;
  logic        last_word;
  logic        nxt_active;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign take      = bus.rx_valid && bus.rx_ready;
  assign hdr_count = {count_hi, bus.rx_data};
  assign last_word = (32'(words_loaded) + 32'd1) == {16'd0, count};

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_HDR_HI;
      S_HDR_HI: if (take) nxt = S_HDR_LO;
      S_HDR_LO: begin
        if (take) begin
          if (hdr_count == 16'd0)                nxt = S_TAIL;
          else if (32'(hdr_count) > CAPACITY)    nxt = S_ERR;
          else                                   nxt = S_DATA;
        end
      end
      S_DATA: if (take && byte_idx == 2'd3 && last_word) nxt = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (take) nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nxt_active = (nxt == S_HDR_HI) || (nxt == S_HDR_LO) || (nxt == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nxt == S_CSUM) nxt_active = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= 32'd0;
      count_hi       <= 8'd0;
      count          <= 16'd0;
      byte_idx       <= 2'd0;
      partial        <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= 8'd0;
`endif
    end else begin
      state        <= nxt;
      cpu_reset    <= (nxt != S_DONE);
      busy         <= nxt_active;
      bus.rx_ready <= nxt_active;
      done         <= (nxt == S_DONE);
      error        <= (nxt == S_ERR);
      bus.imem_we  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) words_loaded <= '0;
        S_HDR_HI: if (take) count_hi <= bus.rx_data;
        S_HDR_LO: begin
          if (take) begin
            count    <= hdr_count;
            byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        S_DATA: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
            // Fourth byte completes the word; address uses the pre-increment count.
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {partial, bus.rx_data};
              bus.imem_addr  <= BASE_ADDR + (32'(words_loaded) << 2);
              words_loaded   <= words_loaded + (ADDR_WIDTH+1)'(1);
            end else begin
              partial <= {partial[15:0], bus.rx_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven self-checking bench for imem_loader
module tb_imem_loader;
  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          cpu_reset, busy, done, error;
  logic [AW:0]   words_loaded;

  imem_loader_if bus();

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    int                n;
    logic [0:13][7:0]  b;
    bit                tog;
    bit                trl;
    bit                exp_done;
    bit                exp_err;
    int                nw;
    logic [0:2][31:0]  w;
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] wr_addr[$], wr_data[$];
  time         wr_t[$], exp_t[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_t.push_back($time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input int n, input logic [0:13][7:0] b,
                         input bit tog, input bit trl, input bit d, input bit e, input int nw,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    vecs[i].name = nm;  vecs[i].n = n;  vecs[i].b = b;  vecs[i].tog = tog;  vecs[i].trl = trl;
    vecs[i].exp_done = d;  vecs[i].exp_err = e;  vecs[i].nw = nw;
    vecs[i].w[0] = w0;  vecs[i].w[1] = w1;  vecs[i].w[2] = w2;
  endtask

  // off = stream position of the first data byte relative to tx_q[0]
  task automatic send(input bit tog, input int off);
    int idx = 0;
    int guard = 0;
    int c = 0;
    bit v;
    while (idx < tx_q.size() && guard < 40) begin
      v = tog ? (c % 2 == 0) : 1'b1;
      c++;
      bus.rx_valid = v;
      bus.rx_data  = tx_q[idx];
      if (v && bus.rx_ready === 1'b1) begin
        if (idx - off >= 0 && (idx - off) % 4 == 3) exp_t.push_back($time);
        idx++;
        guard = 0;
      end else begin
        guard++;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chk("send.bytes_taken", 32'(idx), 32'(tx_q.size()));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_end(input string nm, input int wb, input int eb,
                           input bit d, input bit e, input int wl);
    repeat (3) @(negedge clk);
    chk({nm, ".done"},      32'(done),          32'(d));
    chk({nm, ".error"},     32'(error),         32'(e));
    chk({nm, ".cpu_reset"}, 32'(cpu_reset),     32'(!d));
    chk({nm, ".busy"},      32'(busy),          32'd0);
    chk({nm, ".rx_ready"},  32'(bus.rx_ready),  32'd0);
    chk({nm, ".words"},     32'(words_loaded),  32'(wl));
    chk({nm, ".nwrites"},   32'(wr_addr.size() - wb), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++) begin
      if (wb + k < wr_addr.size() && eb + k < exp_t.size()) begin
        chk({nm, ".addr"},    wr_addr[wb+k], BASE + 32'(4*k));
        chk({nm, ".data"},    wr_data[wb+k], exp_w[k]);
        chk({nm, ".latency"}, 32'(wr_t[wb+k] - exp_t[eb+k]), 32'd10);
      end
    end
  endtask

  task automatic add_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int j = 2; j < tx_q.size(); j++) x ^= tx_q[j];
    tx_q.push_back(x);
`endif
  endtask

  task automatic run_vec(input int i);
    int wb = wr_addr.size();
    int eb = exp_t.size();
    tx_q.delete();
    for (int j = 0; j < vecs[i].n; j++) tx_q.push_back(vecs[i].b[j]);
    if (vecs[i].trl) add_trailer();
    exp_w.delete();
    for (int k = 0; k < vecs[i].nw; k++) exp_w.push_back(vecs[i].w[k]);
    pulse_start();
    send(vecs[i].tog, 2);
    check_end(vecs[i].name, wb, eb, vecs[i].exp_done, vecs[i].exp_err,
              vecs[i].exp_done ? vecs[i].nw : 0);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, ".cpu_reset"}, 32'(cpu_reset),    32'd1);
    chk({nm, ".busy"},      32'(busy),         32'd0);
    chk({nm, ".done"},      32'(done),         32'd0);
    chk({nm, ".error"},     32'(error),        32'd0);
    chk({nm, ".rx_ready"},  32'(bus.rx_ready), 32'd0);
    chk({nm, ".imem_we"},   32'(bus.imem_we),  32'd0);
    chk({nm, ".imem_addr"}, bus.imem_addr,     BASE);
    chk({nm, ".imem_wdata"},bus.imem_wdata,    32'd0);
    chk({nm, ".words"},     32'(words_loaded), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, eb;
    logic [7:0] bb;

    set_vec(0, "two_words",   10, 112'h0002200800050000000800000000, 0, 1, 1, 0, 2,
            32'h20080005, 32'h00000008, 32'h0);
    set_vec(1, "two_words_tog", 10, 112'h0002200800050000000800000000, 1, 1, 1, 0, 2,
            32'h20080005, 32'h00000008, 32'h0);
    set_vec(2, "over_cap",    2,  112'h0101000000000000000000000000, 0, 0, 0, 1, 0,
            32'h0, 32'h0, 32'h0);
    set_vec(3, "zero_count",  2,  112'h0000000000000000000000000000, 0, 1, 1, 0, 0,
            32'h0, 32'h0, 32'h0);
    set_vec(4, "one_word",    6,  112'h0001DEADBEEF0000000000000000, 0, 1, 1, 0, 1,
            32'hDEADBEEF, 32'h0, 32'h0);
    set_vec(5, "three_words", 14, 112'h000311223344556677889900AABB, 1, 1, 1, 0, 3,
            32'h11223344, 32'h55667788, 32'h9900AABB);

    reset = 1'b1;  start = 1'b0;  bus.rx_valid = 1'b0;  bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i);

    // reset in the middle of word 0: nothing written, outputs back to reset values
    wb = wr_addr.size();
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'h02); tx_q.push_back(8'h20); tx_q.push_back(8'h08);
    pulse_start();
    send(0, 2);
    chk("midreset.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset.nwrites", 32'(wr_addr.size() - wb), 32'd0);
    run_vec(0);

    // start during DATA is ignored
    wb = wr_addr.size();  eb = exp_t.size();
    exp_w.delete(); exp_w.push_back(32'h20080005); exp_w.push_back(32'h00000008);
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'h02); tx_q.push_back(8'h20); tx_q.push_back(8'h08);
    tx_q.push_back(8'h00); tx_q.push_back(8'h05);
    pulse_start();
    send(0, 2);
    pulse_start();
    chk("start_in_data.busy",  32'(busy),         32'd1);
    chk("start_in_data.words", 32'(words_loaded), 32'd1);
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h08);
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h25);
`endif
    send(0, -4);
    check_end("start_in_data", wb, eb, 1, 0, 2);

    // start in DONE re-asserts cpu_reset next cycle and expects a new header
    pulse_start();
    chk("restart.cpu_reset", 32'(cpu_reset),    32'd1);
    chk("restart.done",      32'(done),         32'd0);
    chk("restart.rx_ready",  32'(bus.rx_ready), 32'd1);
    chk("restart.words",     32'(words_loaded), 32'd0);
    wb = wr_addr.size();  eb = exp_t.size();
    exp_w.delete();
    tx_q.delete(); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    add_trailer();
    send(0, 2);
    check_end("restart", wb, eb, 1, 0, 0);

    // full capacity: 256 words
    wb = wr_addr.size();  eb = exp_t.size();
    exp_w.delete();
    tx_q.delete(); tx_q.push_back(8'h01); tx_q.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      bb = 8'(k);
      exp_w.push_back({bb, ~bb, bb ^ 8'h5A, 8'hC3});
      tx_q.push_back(bb); tx_q.push_back(~bb); tx_q.push_back(bb ^ 8'h5A); tx_q.push_back(8'hC3);
    end
    add_trailer();
    pulse_start();
    send(0, 2);
    check_end("full_cap", wb, eb, 1, 0, 256);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wb = wr_addr.size();  eb = exp_t.size();
    exp_w.delete(); exp_w.push_back(32'h12345678);
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'h01); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    tx_q.push_back(8'h56); tx_q.push_back(8'h78); tx_q.push_back(8'h08);
    pulse_start();
    send(0, 2);
    check_end("csum_good", wb, eb, 1, 0, 1);
    wb = wr_addr.size();  eb = exp_t.size();
    tx_q[6] = 8'h09;
    pulse_start();
    send(0, 2);
    check_end("csum_bad", wb, eb, 0, 1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory.
- Accepts a byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words and writes them to consecutive word addresses through a single write port.
- Holds the processor in reset (`cpu_reset`) while loading; releases it only after a complete, valid image has been written.
- Sits between the host byte source (e.g. a UART receiver) and the instruction memory write port plus the CPU reset input.

Parameters:
- ADDR_WIDTH, 8, word-address bits of instruction memory; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load session
- rx_valid  input  1  rx_data holds a valid byte
- rx_data  input  8  stream byte
- rx_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write enable, one-cycle pulse
- imem_addr  output  32  byte address of the write (word aligned)
- imem_wdata  output  32  instruction word to write
- cpu_reset  output  1  processor reset; high while not in DONE
- busy  output  1  session in progress (HDR_HI, HDR_LO, DATA)
- done  output  1  image loaded successfully
- error  output  1  session aborted
- words_loaded  output  ADDR_WIDTH+1  words written in current/last session

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE; cpu_reset = 1.
  - rx_ready = 0, imem_we = 0, busy = 0, done = 0, error = 0.
  - imem_addr = BASE_ADDR, imem_wdata = 0, words_loaded = 0.
- Byte handshake: a byte is accepted on a cycle with rx_valid && rx_ready. rx_ready = 1 only in HDR_HI, HDR_LO, DATA; at most one byte per cycle.
- States:
  - IDLE: start -> HDR_HI; clear words_loaded, done and error.
  - HDR_HI: accepted byte -> count[15:8]; go to HDR_LO.
  - HDR_LO: accepted byte -> count[7:0].
    - count == 0 -> DONE.
    - count > 2^ADDR_WIDTH -> ERR.
    - otherwise -> DATA, byte index = 0.
  - DATA: bytes packed MSB first (byte 0 -> [31:24] ... byte 3 -> [7:0]).
    - On the 4th byte: imem_we = 1 the next cycle, with imem_wdata = assembled word and imem_addr = BASE_ADDR + 4*words_loaded (old value); words_loaded increments in that same cycle.
    - After the word with index count-1 is written -> DONE.
  - DONE: done = 1, cpu_reset = 0. start -> HDR_HI (cpu_reset re-asserts the following cycle).
  - ERR: error = 1, cpu_reset = 1. start -> HDR_HI.
- start is ignored in HDR_HI, HDR_LO and DATA.
- cpu_reset is registered and equals (next_state != DONE).
- Write latency: exactly 1 cycle from acceptance of a word's 4th byte to the imem_we pulse; never two pulses back-to-back faster than the byte rate.
- A partial word left at an aborted session is discarded and never written.
- imem_addr wrap: impossible by construction, since count is checked against capacity.
- Reset mid-session: immediately returns to the reset values; a pending imem_we is suppressed; memory contents already written are not undone.
- rx_valid while rx_ready = 0: byte not consumed; the source must hold it.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A state CSUM follows the last data word; it accepts one trailer byte.
  - Trailer equals the XOR of all 4*count data bytes -> DONE; otherwise -> ERR.
  - The count == 0 path also passes through CSUM; the expected value is 8'h00.
  - imem writes still happen during DATA, so an ERR image remains in memory but the CPU stays in reset.
- Disabled: no trailer byte; DATA goes directly to DONE; CSUM logic is absent.

Test Plan:
- Reset then start, stream 00 02 | 20 08 00 05 | 00 00 00 08 with rx_valid held high -> imem_we pulses:
  - addr 0x0, data 0x20080005;
  - addr 0x4, data 0x00000008, each 1 cycle after its 4th byte.
  - Then done = 1, cpu_reset = 0, words_loaded = 2.
- Same stream with rx_valid toggling 1/0 every cycle -> identical writes and values; no byte lost or duplicated.
- Header 01 01 with ADDR_WIDTH = 8 (257 > 256) -> ERR, error = 1, cpu_reset = 1, no imem_we; a following start with header 00 00 -> DONE.
- Reset asserted after 2 data bytes of word 1 -> no imem_we, all outputs at reset values the next cycle; start is accepted afterwards.
- start pulsed during DATA -> ignored, load completes normally; start in DONE -> cpu_reset = 1 on the next cycle, new header expected.
- With IMEM_LOADER_CHECKSUM_EN, stream 00 01 | 12 34 56 78 | 08 -> DONE; trailer 09 instead -> ERR, cpu_reset stays 1.
